multicycle_controller: RTL and testbench

- Moore-style FSM control unit for a multi-cycle RISC-V datapath (RV32I subset: R-ALU, I-ALU, lw, sw, beq/bne/blt/bge, jal, jalr, lui).
- Shares one memory port and one ALU across instruction phases. Drives the mux selects and write enables of the datapath's internal PC, OldPC, IR, MDR, A, B and ALUOut registers.
- Takes zero, sign, f3, f7 and opc back from the datapath.
- Replaces the single-cycle controller when the team builds the multi-cycle processor.

---
 rtl/multicycle_controller.sv | 258 +++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Moore-style control FSM for a multi-cycle RV32I datapath.
// One memory port and one ALU are shared across instruction phases. Every
// output is decoded from the state register, plus zero/sign in BRANCH,
// f3/f7 for the ALU operation, and opc for IMMsrc.
// MEM_WAIT extra cycles are spent in FETCH and in MEMREAD.
module multicycle_controller #(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       zero,
  input  logic       sign,
  input  logic [2:0] f3,
  input  logic [6:0] f7,
  input  logic [6:0] opc,
  output logic       PCwrite,
  output logic       adrsrc,
  output logic       memwrite,
  output logic       IRwrite,
  output logic       regwrite,
  output logic [1:0] resultsrc,
  output logic [1:0] ALUsrcA,
  output logic [1:0] ALUsrcB,
  output logic [2:0] ALUcontrol,
  output logic [2:0] IMMsrc,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_JALRPC   = 4'd12,
    S_LINKWB   = 4'd13,
    S_LUI      = 4'd14,
    S_UNUSED   = 4'd15
  } state_t;

  localparam logic [6:0] OPC_R    = 7'b0110011;
  localparam logic [6:0] OPC_I    = 7'b0010011;
  localparam logic [6:0] OPC_LW   = 7'b0000011;
  localparam logic [6:0] OPC_SW   = 7'b0100011;
  localparam logic [6:0] OPC_BR   = 7'b1100011;
  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam logic [6:0] OPC_LUI  = 7'b0110111;

  localparam logic [3:0] MEM_WAIT_C = 4'(MEM_WAIT);

  state_t     state_r, state_nxt_s;
  logic [3:0] cnt_r, cnt_nxt_s;
  logic       unused_f7_s;

  // Only f7[5] takes part in decode (sub vs add).
  assign unused_f7_s = ^{f7[6], f7[4:0]};

  // ALU operation for EXECR/EXECI; sub is only valid for R-type.
  function automatic logic [2:0] alu_dec(input logic [2:0] fn3,
                                         input logic is_r,
                                         input logic f7b5);
    logic [2:0] op;
    case (fn3)
      3'b000:  op = (is_r && f7b5) ? 3'b001 : 3'b000;
      3'b111:  op = 3'b010;
      3'b110:  op = 3'b011;
      3'b010:  op = 3'b100;
      3'b100:  op = 3'b101;
      default: op = 3'b000;
    endcase
    return op;
  endfunction

  // Immediate format, chosen by opcode alone.
  function automatic logic [2:0] imm_dec(input logic [6:0] op_code);
    logic [2:0] im;
    case (op_code)
      OPC_LW, OPC_JALR, OPC_I: im = 3'b000;
      OPC_SW:                  im = 3'b001;
      OPC_BR:                  im = 3'b010;
      OPC_JAL:                 im = 3'b011;
      OPC_LUI:                 im = 3'b100;
      default:                 im = 3'b000;
    endcase
    return im;
  endfunction

  // Branch decision from f3 and the flags of A - B.
  function automatic logic br_take(input logic [2:0] fn3,
                                   input logic z, input logic s);
    logic tk;
    case (fn3)
      3'b000:  tk = z;
      3'b001:  tk = ~z;
      3'b100:  tk = s;
      3'b101:  tk = ~s;
      default: tk = 1'b0;
    endcase
    return tk;
  endfunction

  // State register and shared memory-wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_FETCH;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state and Moore output decode; write enables are gated off in reset.
  always_comb begin
    state_nxt_s = S_FETCH;
    cnt_nxt_s   = 4'd0;
    PCwrite     = 1'b0;
    adrsrc      = 1'b0;
    memwrite    = 1'b0;
    IRwrite     = 1'b0;
    regwrite    = 1'b0;
    resultsrc   = 2'b00;
    ALUsrcA     = 2'b00;
    ALUsrcB     = 2'b00;
    ALUcontrol  = 3'b000;
    IMMsrc      = imm_dec(opc);
    case (state_r)
      S_FETCH: begin
        adrsrc    = 1'b0;
        ALUsrcA   = 2'b00;
        ALUsrcB   = 2'b10;
        resultsrc = 2'b10;
        if (cnt_r != MEM_WAIT_C) begin
          cnt_nxt_s   = cnt_r + 4'd1;
          state_nxt_s = S_FETCH;
        end else begin
          IRwrite     = 1'b1;
          PCwrite     = 1'b1;
          cnt_nxt_s   = 4'd0;
          state_nxt_s = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUsrcA = 2'b01;
        ALUsrcB = 2'b01;
        case (opc)
          OPC_R:          state_nxt_s = S_EXECR;
          OPC_I:          state_nxt_s = S_EXECI;
          OPC_LW, OPC_SW: state_nxt_s = S_MEMADR;
          OPC_BR:         state_nxt_s = S_BRANCH;
          OPC_JAL:        state_nxt_s = S_JAL;
          OPC_JALR:       state_nxt_s = S_JALR;
          OPC_LUI:        state_nxt_s = S_LUI;
          default:        state_nxt_s = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUsrcA = 2'b10;
        ALUsrcB = 2'b01;
        if (opc == OPC_LW) begin
          state_nxt_s = S_MEMREAD;
        end else if (opc == OPC_SW) begin
          state_nxt_s = S_MEMWRITE;
        end else begin
          state_nxt_s = S_FETCH;
        end
      end
      S_MEMREAD: begin
        adrsrc = 1'b1;
        if (cnt_r != MEM_WAIT_C) begin
          cnt_nxt_s   = cnt_r + 4'd1;
          state_nxt_s = S_MEMREAD;
        end else begin
          cnt_nxt_s   = 4'd0;
          state_nxt_s = S_MEMWB;
        end
      end
      S_MEMWB: begin
        resultsrc = 2'b01;
        regwrite  = 1'b1;
      end
      S_MEMWRITE: begin
        adrsrc   = 1'b1;
        memwrite = 1'b1;
      end
      S_EXECR: begin
        ALUsrcA     = 2'b10;
        ALUsrcB     = 2'b00;
        ALUcontrol  = alu_dec(f3, 1'b1, f7[5]);
        state_nxt_s = S_ALUWB;
      end
      S_EXECI: begin
        ALUsrcA     = 2'b10;
        ALUsrcB     = 2'b01;
        ALUcontrol  = alu_dec(f3, 1'b0, f7[5]);
        state_nxt_s = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite = 1'b1;
      end
      S_BRANCH: begin
        ALUsrcA    = 2'b10;
        ALUsrcB    = 2'b00;
        ALUcontrol = 3'b001;
        PCwrite    = br_take(f3, zero, sign);
      end
      S_JAL: begin
        PCwrite     = 1'b1;
        ALUsrcA     = 2'b01;
        ALUsrcB     = 2'b10;
        state_nxt_s = S_LINKWB;
      end
      S_JALR: begin
        ALUsrcA     = 2'b10;
        ALUsrcB     = 2'b01;
        state_nxt_s = S_JALRPC;
      end
      S_JALRPC: begin
        PCwrite     = 1'b1;
        ALUsrcA     = 2'b01;
        ALUsrcB     = 2'b10;
        state_nxt_s = S_LINKWB;
      end
      S_LINKWB: begin
        regwrite = 1'b1;
      end
      S_LUI: begin
        resultsrc = 2'b11;
        regwrite  = 1'b1;
      end
      default: begin
        state_nxt_s = S_FETCH;
      end
    endcase
    if (rst) begin
      PCwrite  = 1'b0;
      IRwrite  = 1'b0;
      memwrite = 1'b0;
      regwrite = 1'b0;
    end else begin
      PCwrite  = PCwrite;
      IRwrite  = IRwrite;
      memwrite = memwrite;
      regwrite = regwrite;
    end
  end

  assign state = state_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: a MEM_WAIT=0 instance and a
// MEM_WAIT=2 instance share their inputs; expected values are hand-computed.
module tb_multicycle_controller;

  logic       clk, rst, zero, sign;
  logic [2:0] f3;
  logic [6:0] f7, opc;

  logic       pcw_0, adr_0, mw_0, irw_0, rw_0;
  logic [1:0] rs_0, sa_0, sb_0;
  logic [2:0] ac_0, im_0;
  logic [3:0] st_0;

  logic       pcw_2, adr_2, mw_2, irw_2, rw_2;
  logic [1:0] rs_2, sa_2, sb_2;
  logic [2:0] ac_2, im_2;
  logic [3:0] st_2;

  int checks = 0;
  int errors = 0;

  multicycle_controller #(.MEM_WAIT(0)) u_dut0 (
    .clk(clk), .rst(rst), .zero(zero), .sign(sign), .f3(f3), .f7(f7), .opc(opc),
    .PCwrite(pcw_0), .adrsrc(adr_0), .memwrite(mw_0), .IRwrite(irw_0),
    .regwrite(rw_0), .resultsrc(rs_0), .ALUsrcA(sa_0), .ALUsrcB(sb_0),
    .ALUcontrol(ac_0), .IMMsrc(im_0), .state(st_0)
  );

  multicycle_controller #(.MEM_WAIT(2)) u_dut2 (
    .clk(clk), .rst(rst), .zero(zero), .sign(sign), .f3(f3), .f7(f7), .opc(opc),
    .PCwrite(pcw_2), .adrsrc(adr_2), .memwrite(mw_2), .IRwrite(irw_2),
    .regwrite(rw_2), .resultsrc(rs_2), .ALUsrcA(sa_2), .ALUsrcB(sb_2),
    .ALUcontrol(ac_2), .IMMsrc(im_2), .state(st_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write enables of the MEM_WAIT=0 instance packed as {PC, IR, reg, mem}.
  function automatic logic [7:0] we0();
    return {4'd0, pcw_0, irw_0, rw_0, mw_0};
  endfunction

  logic [3:0] lw_st [9];
  logic       lw_ir [9];
  logic       lw_rw [9];

  initial begin
    rst = 1'b1; zero = 1'b0; sign = 1'b0;
    f3 = 3'b000; f7 = 7'b0100000; opc = 7'b0110011;

    // Reset held for two cycles.
    tick();
    chk("rst1_state", 8'(st_0), 8'd0);
    chk("rst1_we", we0(), 8'd0);
    tick();
    chk("rst2_state", 8'(st_0), 8'd0);
    chk("rst2_we", we0(), 8'd0);
    chk("rst2_state_w2", 8'(st_2), 8'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_we", we0(), 8'b1100);

    // R-type sub: 0,1,6,8,0.
    tick(); chk("r_dec", 8'(st_0), 8'd1);
    chk("r_dec_we", we0(), 8'd0);
    tick(); chk("r_exec", 8'(st_0), 8'd6);
    chk("r_exec_alu", 8'(ac_0), 8'b001);
    chk("r_exec_src", 8'({sa_0, sb_0}), 8'b1000);
    chk("r_exec_we", we0(), 8'd0);
    tick(); chk("r_wb", 8'(st_0), 8'd8);
    chk("r_wb_we", we0(), 8'b0010);
    chk("r_wb_rs", 8'(rs_0), 8'b00);
    tick(); chk("r_end", 8'(st_0), 8'd0);

    // I-type add with f7[5]=1 must stay add; f3=100 is xor.
    opc = 7'b0010011; f3 = 3'b000;
    tick(); tick(); chk("i_exec", 8'(st_0), 8'd7);
    chk("i_exec_alu", 8'(ac_0), 8'b000);
    f3 = 3'b100; #1;
    chk("i_exec_xor", 8'(ac_0), 8'b101);
    tick(); tick(); chk("i_end", 8'(st_0), 8'd0);

    // beq taken / not taken.
    opc = 7'b1100011; f3 = 3'b000; zero = 1'b1; #1;
    chk("beq_imm", 8'(im_0), 8'b010);
    tick(); tick(); chk("beq_st", 8'(st_0), 8'd9);
    chk("beq_alu", 8'(ac_0), 8'b001);
    chk("beq_taken", 8'(pcw_0), 8'd1);
    zero = 1'b0; #1;
    chk("beq_not", 8'(pcw_0), 8'd0);
    f3 = 3'b001; #1;
    chk("bne_taken", 8'(pcw_0), 8'd1);
    tick(); chk("beq_end", 8'(st_0), 8'd0);

    // bge: sign=0 taken, sign=1 not.
    f3 = 3'b101; sign = 1'b0;
    tick(); tick(); chk("bge_st", 8'(st_0), 8'd9);
    chk("bge_taken", 8'(pcw_0), 8'd1);
    sign = 1'b1; #1;
    chk("bge_not", 8'(pcw_0), 8'd0);
    tick(); chk("bge_end", 8'(st_0), 8'd0);
    sign = 1'b0;

    // jalr: 0,1,11,12,13,0.
    opc = 7'b1100111; f3 = 3'b000;
    tick(); chk("jalr_dec", 8'(st_0), 8'd1);
    chk("jalr_imm", 8'(im_0), 8'b000);
    tick(); chk("jalr_st", 8'(st_0), 8'd11);
    chk("jalr_we", we0(), 8'd0);
    tick(); chk("jalrpc_st", 8'(st_0), 8'd12);
    chk("jalrpc_we", we0(), 8'b1000);
    chk("jalrpc_imm", 8'(im_0), 8'b000);
    tick(); chk("link_st", 8'(st_0), 8'd13);
    chk("link_we", we0(), 8'b0010);
    tick(); chk("jalr_end", 8'(st_0), 8'd0);

    // lui: 0,1,14,0.
    opc = 7'b0110111;
    tick(); tick(); chk("lui_st", 8'(st_0), 8'd14);
    chk("lui_rs", 8'(rs_0), 8'b11);
    chk("lui_imm", 8'(im_0), 8'b100);
    chk("lui_we", we0(), 8'b0010);
    tick(); chk("lui_end", 8'(st_0), 8'd0);

    // sw: 0,1,2,5,0 with one memwrite cycle.
    opc = 7'b0100011;
    tick(); tick(); chk("sw_adr", 8'(st_0), 8'd2);
    tick(); chk("sw_st", 8'(st_0), 8'd5);
    chk("sw_we", we0(), 8'b0001);
    chk("sw_adrsrc", 8'(adr_0), 8'd1);
    tick(); chk("sw_end", 8'(st_0), 8'd0);
    chk("sw_end_we", we0(), 8'b1100);

    // Illegal opcode: DECODE then FETCH, no writes.
    opc = 7'b1111111;
    tick(); chk("ill_dec", 8'(st_0), 8'd1);
    chk("ill_we", we0(), 8'd0);
    tick(); chk("ill_end", 8'(st_0), 8'd0);

    // Reset during EXECR: back to FETCH, ALUWB never reached.
    opc = 7'b0110011; f3 = 3'b000;
    tick(); tick(); chk("rmid_exec", 8'(st_0), 8'd6);
    rst = 1'b1;
    tick(); chk("rmid_state", 8'(st_0), 8'd0);
    chk("rmid_we", we0(), 8'd0);
    rst = 1'b0;
    // Reset asserted while in ALUWB gates regwrite.
    tick(); tick(); tick(); chk("rwb_st", 8'(st_0), 8'd8);
    rst = 1'b1; #1;
    chk("rwb_gated", 8'(rw_0), 8'd0);
    tick(); chk("rwb_state", 8'(st_0), 8'd0);

    // lw on the MEM_WAIT=2 instance, starting right after reset release.
    lw_st = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4};
    lw_ir = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    lw_rw = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    opc = 7'b0000011;
    tick();
    rst = 1'b0; #1;
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("lw_state_c%0d", i), 8'(st_2), 8'(lw_st[i]));
      chk($sformatf("lw_irw_c%0d", i), 8'(irw_2), 8'(lw_ir[i]));
      chk($sformatf("lw_rw_c%0d", i), 8'(rw_2), 8'(lw_rw[i]));
      if (lw_st[i] == 4'd3) chk($sformatf("lw_adr_c%0d", i), 8'(adr_2), 8'd1);
      if (lw_st[i] == 4'd4) chk("lw_wb_rs", 8'(rs_2), 8'b01);
      tick();
    end
    chk("lw_end", 8'(st_2), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
